// File: rtl/regfile_write_port_scheduler.sv
// Register-file write port scheduler.
// Arbitrates the single register-file write port between the in-order
// writeback stage and the asynchronous MDU. One MDU result can be parked
// while writeback owns the port. If that result loses arbitration
// STARVE_LIMIT times in a row, the pipeline is frozen for one cycle so the
// parked result can drain.
module regfile_write_port_scheduler #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wbValid,
    input  logic [DEPTH-1:0] wbAddress,
    input  logic [WIDTH-1:0] wbData,
    input  logic             mduValid,
    input  logic [DEPTH-1:0] mduAddress,
    input  logic [WIDTH-1:0] mduData,
    output logic             mduReady,
    output logic             stallPipeline,
    output logic             enableWriteRegisterFile,
    output logic [DEPTH-1:0] addressWriteRegisterFile,
    output logic [WIDTH-1:0] dataToWriteRegisterFile,
    output logic             pendingValid,
    output logic [DEPTH-1:0] pendingAddress
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] FORCE = 2'd2;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]       state, stateNext;
    logic             holdValid, holdValidNext;
    logic [DEPTH-1:0] holdAddress, holdAddressNext;
    logic [WIDTH-1:0] holdData, holdDataNext;
    logic [3:0]       starveCount, starveCountNext, starveCountInc;
    logic             writeEnableNext;
    logic [DEPTH-1:0] writeAddressNext;
    logic [WIDTH-1:0] writeDataNext;
    logic             wbEffective;
    logic             mduEffective;

    // Writes to r0 are meaningless, so they never count as requests.
    assign wbEffective    = wbValid && (wbAddress != '0);
    assign mduEffective   = mduValid && mduReady && (mduAddress != '0);
    assign mduReady       = (state == IDLE) && !reset;
    assign stallPipeline  = (state == FORCE);
    assign pendingValid   = holdValid;
    assign pendingAddress = holdValid ? holdAddress : '0;
    // Lost-arbitration count, saturating at the limit.
    assign starveCountInc = (starveCount < LIMIT) ? starveCount + 4'd1 : starveCount;

    // Select this cycle's winner and the next hold/FSM contents.
    always_comb begin
        stateNext        = state;
        holdValidNext    = holdValid;
        holdAddressNext  = holdAddress;
        holdDataNext     = holdData;
        starveCountNext  = starveCount;
        writeEnableNext  = 1'b0;
        writeAddressNext = addressWriteRegisterFile;
        writeDataNext    = dataToWriteRegisterFile;
        case (state)
            IDLE: begin
                if (wbEffective) begin
                    writeEnableNext  = 1'b1;
                    writeAddressNext = wbAddress;
                    writeDataNext    = wbData;
                    // Same destination: the younger writeback value supersedes the MDU result.
                    if (mduEffective && (mduAddress != wbAddress)) begin
                        holdValidNext   = 1'b1;
                        holdAddressNext = mduAddress;
                        holdDataNext    = mduData;
                        starveCountNext = 4'd0;
                        stateNext       = HOLD;
                    end
                end else if (mduEffective) begin
                    writeEnableNext  = 1'b1;
                    writeAddressNext = mduAddress;
                    writeDataNext    = mduData;
                end
            end
            HOLD: begin
                if (wbEffective) begin
                    writeEnableNext  = 1'b1;
                    writeAddressNext = wbAddress;
                    writeDataNext    = wbData;
                    if (wbAddress == holdAddress) begin
                        // Write-after-write: the held value is dead, discard it.
                        holdValidNext   = 1'b0;
                        starveCountNext = 4'd0;
                        stateNext       = IDLE;
                    end else begin
                        starveCountNext = starveCountInc;
                        if (starveCountInc >= LIMIT) begin
                            stateNext = FORCE;
                        end
                    end
                end else begin
                    writeEnableNext  = 1'b1;
                    writeAddressNext = holdAddress;
                    writeDataNext    = holdData;
                    holdValidNext    = 1'b0;
                    starveCountNext  = 4'd0;
                    stateNext        = IDLE;
                end
            end
            FORCE: begin
                // Pipeline is frozen; the held result owns the port unconditionally.
                writeEnableNext  = 1'b1;
                writeAddressNext = holdAddress;
                writeDataNext    = holdData;
                holdValidNext    = 1'b0;
                starveCountNext  = 4'd0;
                stateNext        = IDLE;
            end
            default: begin
                holdValidNext   = 1'b0;
                starveCountNext = 4'd0;
                stateNext       = IDLE;
            end
        endcase
    end

    // Register FSM, hold slot and register-file write outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                    <= IDLE;
            holdValid                <= 1'b0;
            holdAddress              <= '0;
            holdData                 <= '0;
            starveCount              <= 4'd0;
            enableWriteRegisterFile  <= 1'b0;
            addressWriteRegisterFile <= '0;
            dataToWriteRegisterFile  <= '0;
        end else begin
            state                    <= stateNext;
            holdValid                <= holdValidNext;
            holdAddress              <= holdAddressNext;
            holdData                 <= holdDataNext;
            starveCount              <= starveCountNext;
            enableWriteRegisterFile  <= writeEnableNext;
            addressWriteRegisterFile <= writeAddressNext;
            dataToWriteRegisterFile  <= writeDataNext;
        end
    end

endmodule

// File: tb/tb_regfile_write_port_scheduler.sv
// Testbench for regfile_write_port_scheduler.
// Expected register-file writes are queued as stimulus is applied. Writes
// observed on the DUT outputs are queued each cycle, and every scenario
// task compares the two queues.
module tb_regfile_write_port_scheduler;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int LIMIT = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             wbValid;
    logic [DEPTH-1:0] wbAddress;
    logic [WIDTH-1:0] wbData;
    logic             mduValid;
    logic [DEPTH-1:0] mduAddress;
    logic [WIDTH-1:0] mduData;
    logic             mduReady;
    logic             stallPipeline;
    logic             enableWriteRegisterFile;
    logic [DEPTH-1:0] addressWriteRegisterFile;
    logic [WIDTH-1:0] dataToWriteRegisterFile;
    logic             pendingValid;
    logic [DEPTH-1:0] pendingAddress;

    logic [DEPTH+WIDTH-1:0] expQ[$];
    logic [DEPTH+WIDTH-1:0] obsQ[$];
    logic [DEPTH+WIDTH-1:0] gotWr, expWr;
    int checks   = 0;
    int failures = 0;

    regfile_write_port_scheduler #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .wbValid(wbValid), .wbAddress(wbAddress), .wbData(wbData),
        .mduValid(mduValid), .mduAddress(mduAddress), .mduData(mduData),
        .mduReady(mduReady), .stallPipeline(stallPipeline),
        .enableWriteRegisterFile(enableWriteRegisterFile),
        .addressWriteRegisterFile(addressWriteRegisterFile),
        .dataToWriteRegisterFile(dataToWriteRegisterFile),
        .pendingValid(pendingValid), .pendingAddress(pendingAddress)
    );

    always #5 clock = ~clock;

    // Advance one clock edge and record any register-file write it produced.
    task automatic tick();
        @(posedge clock);
        #1;
        if (enableWriteRegisterFile === 1'b1)
            obsQ.push_back({addressWriteRegisterFile, dataToWriteRegisterFile});
    endtask

    task automatic driveWb(input logic v, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
        wbValid = v; wbAddress = a; wbData = d;
    endtask

    task automatic driveMdu(input logic v, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
        mduValid = v; mduAddress = a; mduData = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        driveWb(1'b0, '0, '0);
        driveMdu(1'b1, 5'd9, 32'h55);
        tick();
        checks++;
        if (mduReady !== 1'b0) begin
            failures++; $display("FAIL reset_ready_c1: got %b, expected 0", mduReady);
        end
        tick();
        checks++;
        if ({enableWriteRegisterFile, addressWriteRegisterFile, dataToWriteRegisterFile,
             pendingValid, pendingAddress, stallPipeline, mduReady} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b a=%0d d=%h pv=%b pa=%0d st=%b rdy=%b, expected all 0",
                     enableWriteRegisterFile, addressWriteRegisterFile, dataToWriteRegisterFile,
                     pendingValid, pendingAddress, stallPipeline, mduReady);
        end
        reset = 1'b0;
        driveMdu(1'b0, '0, '0);
        #1;
        checks++;
        if (mduReady !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready: got %b, expected 1", mduReady);
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_wb_write();
        driveWb(1'b1, 5'd5, 32'hA5A5A5A5);
        expQ.push_back({5'd5, 32'hA5A5A5A5});
        tick();
        driveWb(1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        checks++;
        if (enableWriteRegisterFile !== 1'b0 || addressWriteRegisterFile !== 5'd5) begin
            failures++;
            $display("FAIL wb_r0_ignored: got en=%b a=%0d, expected en=0 a=5",
                     enableWriteRegisterFile, addressWriteRegisterFile);
        end
        driveWb(1'b0, '0, '0);
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            failures++; $display("FAIL wb_write_count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            gotWr = obsQ.pop_front(); expWr = expQ.pop_front(); checks++;
            if (gotWr !== expWr) begin
                failures++; $display("FAIL wb_write: got %h, expected %h", gotWr, expWr);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_mdu_direct();
        driveMdu(1'b1, 5'd9, 32'h1234);
        #1;
        checks++;
        if (mduReady !== 1'b1) begin
            failures++; $display("FAIL mdu_direct_ready: got %b, expected 1", mduReady);
        end
        expQ.push_back({5'd9, 32'h1234});
        tick();
        driveMdu(1'b0, '0, '0);
        checks++;
        if (pendingValid !== 1'b0) begin
            failures++; $display("FAIL mdu_direct_pending: got %b, expected 0", pendingValid);
        end
        tick();
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            failures++; $display("FAIL mdu_direct_count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            gotWr = obsQ.pop_front(); expWr = expQ.pop_front(); checks++;
            if (gotWr !== expWr) begin
                failures++; $display("FAIL mdu_direct_write: got %h, expected %h", gotWr, expWr);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_hold_drain();
        driveWb(1'b1, 5'd3, 32'h33);
        driveMdu(1'b1, 5'd4, 32'h44);
        expQ.push_back({5'd3, 32'h33});
        tick();
        driveWb(1'b0, '0, '0);
        driveMdu(1'b0, '0, '0);
        checks++;
        if (pendingValid !== 1'b1 || pendingAddress !== 5'd4 || mduReady !== 1'b0) begin
            failures++;
            $display("FAIL hold_loaded: got pv=%b pa=%0d rdy=%b, expected pv=1 pa=4 rdy=0",
                     pendingValid, pendingAddress, mduReady);
        end
        expQ.push_back({5'd4, 32'h44});
        tick();
        checks++;
        if (pendingValid !== 1'b0 || pendingAddress !== 5'd0 || mduReady !== 1'b1) begin
            failures++;
            $display("FAIL hold_drained: got pv=%b pa=%0d rdy=%b, expected pv=0 pa=0 rdy=1",
                     pendingValid, pendingAddress, mduReady);
        end
        tick();
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            failures++; $display("FAIL hold_drain_count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            gotWr = obsQ.pop_front(); expWr = expQ.pop_front(); checks++;
            if (gotWr !== expWr) begin
                failures++; $display("FAIL hold_drain_write: got %h, expected %h", gotWr, expWr);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_starvation();
        driveWb(1'b1, 5'd1, 32'h10);
        driveMdu(1'b1, 5'd4, 32'h44);
        expQ.push_back({5'd1, 32'h10});
        tick();
        driveMdu(1'b0, '0, '0);
        for (int k = 1; k <= LIMIT; k++) begin
            driveWb(1'b1, 5'd1, 32'h10 + k);
            expQ.push_back({5'd1, 32'h10 + k});
            tick();
            checks++;
            if (stallPipeline !== (k == LIMIT)) begin
                failures++;
                $display("FAIL starve_stall_k%0d: got %b, expected %b", k, stallPipeline, (k == LIMIT));
            end
        end
        // Frozen cycle: writeback request stays presented but must be ignored.
        driveWb(1'b1, 5'd1, 32'h99);
        expQ.push_back({5'd4, 32'h44});
        tick();
        checks++;
        if (stallPipeline !== 1'b0 || pendingValid !== 1'b0 || mduReady !== 1'b1) begin
            failures++;
            $display("FAIL starve_after_force: got st=%b pv=%b rdy=%b, expected st=0 pv=0 rdy=1",
                     stallPipeline, pendingValid, mduReady);
        end
        expQ.push_back({5'd1, 32'h99});
        tick();
        driveWb(1'b0, '0, '0);
        tick();
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            failures++; $display("FAIL starve_count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            gotWr = obsQ.pop_front(); expWr = expQ.pop_front(); checks++;
            if (gotWr !== expWr) begin
                failures++; $display("FAIL starve_write: got %h, expected %h", gotWr, expWr);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_waw_and_r0();
        // Held r7 is cancelled by a younger writeback to r7.
        driveWb(1'b1, 5'd2, 32'h22);
        driveMdu(1'b1, 5'd7, 32'h77);
        expQ.push_back({5'd2, 32'h22});
        tick();
        driveMdu(1'b0, '0, '0);
        driveWb(1'b1, 5'd7, 32'h99);
        expQ.push_back({5'd7, 32'h99});
        tick();
        driveWb(1'b0, '0, '0);
        checks++;
        if (pendingValid !== 1'b0 || mduReady !== 1'b1) begin
            failures++; $display("FAIL waw_cancel: got pv=%b rdy=%b, expected pv=0 rdy=1", pendingValid, mduReady);
        end
        tick();
        // Same destination in the same IDLE cycle: MDU value is dropped.
        driveWb(1'b1, 5'd6, 32'h66);
        driveMdu(1'b1, 5'd6, 32'h67);
        expQ.push_back({5'd6, 32'h66});
        tick();
        driveWb(1'b0, '0, '0);
        driveMdu(1'b0, '0, '0);
        checks++;
        if (pendingValid !== 1'b0) begin
            failures++; $display("FAIL same_addr_drop: got pv=%b, expected 0", pendingValid);
        end
        tick();
        // MDU result to r0 is accepted and discarded.
        driveMdu(1'b1, 5'd0, 32'hABCD);
        tick();
        driveMdu(1'b0, '0, '0);
        checks++;
        if (enableWriteRegisterFile !== 1'b0 || pendingValid !== 1'b0) begin
            failures++;
            $display("FAIL mdu_r0_discard: got en=%b pv=%b, expected en=0 pv=0", enableWriteRegisterFile, pendingValid);
        end
        tick();
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            failures++; $display("FAIL waw_count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            gotWr = obsQ.pop_front(); expWr = expQ.pop_front(); checks++;
            if (gotWr !== expWr) begin
                failures++; $display("FAIL waw_write: got %h, expected %h", gotWr, expWr);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_reset_in_force();
        driveWb(1'b1, 5'd1, 32'h100);
        driveMdu(1'b1, 5'd4, 32'h400);
        expQ.push_back({5'd1, 32'h100});
        tick();
        driveMdu(1'b0, '0, '0);
        for (int k = 1; k <= LIMIT; k++) begin
            expQ.push_back({5'd1, 32'h100});
            tick();
        end
        checks++;
        if (stallPipeline !== 1'b1) begin
            failures++; $display("FAIL force_reached: got %b, expected 1", stallPipeline);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        driveWb(1'b0, '0, '0);
        checks++;
        if ({enableWriteRegisterFile, addressWriteRegisterFile, dataToWriteRegisterFile,
             pendingValid, pendingAddress, stallPipeline} !== '0) begin
            failures++;
            $display("FAIL force_reset_zero: got en=%b a=%0d d=%h pv=%b pa=%0d st=%b, expected all 0",
                     enableWriteRegisterFile, addressWriteRegisterFile, dataToWriteRegisterFile,
                     pendingValid, pendingAddress, stallPipeline);
        end
        tick();
        checks++;
        if (enableWriteRegisterFile !== 1'b0 || mduReady !== 1'b1) begin
            failures++;
            $display("FAIL force_reset_no_write: got en=%b rdy=%b, expected en=0 rdy=1",
                     enableWriteRegisterFile, mduReady);
        end
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            failures++; $display("FAIL force_reset_count: got %0d, expected %0d", obsQ.size(), expQ.size());
        end
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            gotWr = obsQ.pop_front(); expWr = expQ.pop_front(); checks++;
            if (gotWr !== expWr) begin
                failures++; $display("FAIL force_reset_write: got %h, expected %h", gotWr, expWr);
            end
        end
        obsQ.delete(); expQ.delete();
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_mdu_direct();
        test_hold_drain();
        test_starvation();
        test_waw_and_r0();
        test_reset_in_force();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_write_port_scheduler.md
Name: regfile_write_port_scheduler

Overview:
Shares the single register-file write port between two writers: the in-order pipeline writeback stage and a multi-cycle execution unit (MDU) that returns results asynchronously to the pipeline. The block holds one MDU result while the writeback stage owns the port, tracks how long that result has waited, and freezes the pipeline for one cycle when the wait limit is reached. It sits between the writeback stage, the MDU and the register file's write inputs, and exports the pending destination to the hazard unit.

Parameters:
WIDTH, 32, data word width
DEPTH, 5, register address width (2**DEPTH registers)
STARVE_LIMIT, 4, consecutive lost arbitration cycles before a forced drain (legal range 1..15)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
wbValid  input  1  writeback stage requests a register write this cycle
wbAddress  input  DEPTH  writeback destination register
wbData  input  WIDTH  writeback data
mduValid  input  1  MDU presents a result
mduAddress  input  DEPTH  MDU destination register
mduData  input  WIDTH  MDU result data
mduReady  output  1  block accepts the MDU result this cycle
stallPipeline  output  1  freeze pipeline; writeback request is ignored this cycle
enableWriteRegisterFile  output  1  registered write enable to register file
addressWriteRegisterFile  output  DEPTH  registered write address
dataToWriteRegisterFile  output  WIDTH  registered write data
pendingValid  output  1  an MDU result is held, not yet written
pendingAddress  output  DEPTH  destination of the held result (0 when pendingValid=0)

Behaviour:
- Reset: state IDLE, hold empty, starve counter 0, enable/address/data = 0, pendingValid=0, pendingAddress=0, stallPipeline=0. mduReady=0 while reset is high.
- States: IDLE (hold empty), HOLD (hold full), FORCE (hold full, forced drain). stallPipeline = (state==FORCE). mduReady = (state==IDLE) and not reset.
- Handshake: an MDU result is accepted when mduValid && mduReady. The MDU keeps its address and data stable until it is accepted.
- A request is effective only if its address is nonzero. wbValid with wbAddress=0 counts as no request. An accepted MDU result to r0 is discarded and never enters the hold.
- Write latency: the winner is sampled at edge N, and the register-file outputs show it from edge N until edge N+1. Exactly one write per cycle. enable=0 when there is no winner; address and data then hold their previous values.
- IDLE: the effective WB request wins the port. If MDU is accepted and WB is not effective, the MDU result is written directly and the hold is never used. If both are effective, WB is written and the MDU result is loaded into the hold, moving to HOLD with counter=0.
- IDLE, same address: if WB and the accepted MDU result target the same register in the same cycle, WB is written and the MDU result is dropped.
- HOLD: an effective WB request wins and the counter is incremented. When the counter reaches STARVE_LIMIT, move to FORCE. If WB is not effective, write the hold, clear it, go to IDLE and clear the counter.
- HOLD, WAW cancel: if an effective WB targets pendingAddress, WB is written, the hold is cleared, and the block goes to IDLE with counter=0.
- FORCE lasts exactly one cycle. stallPipeline=1, wb* inputs are ignored, the hold is written, then the block goes to IDLE with counter=0. The pipeline holds its writeback request stable and re-presents it the next cycle.
- mduReady stays 0 throughout HOLD and FORCE. It returns to 1 in the first IDLE cycle.
- The counter saturates at STARVE_LIMIT and is 4 bits wide.
- Reset mid-operation: the held result is lost, with no write in the cycle following reset. The MDU resends it after reset.

Test Plan:
1. Reset for 2 cycles with mduValid=1 -> all outputs 0 and mduReady=0 during reset. mduReady=1 in the first cycle after reset deasserts.
2. wbValid=1, wbAddress=5, wbData=0xA5A5A5A5 -> next cycle enable=1, address=5, data=0xA5A5A5A5. wbAddress=0 -> enable=0.
3. mduValid=1 alone with mduAddress=9, mduData=0x1234 -> accepted that cycle, next cycle writes r9=0x1234, pendingValid stays 0.
4. Same cycle: WB r3=0x33 and MDU r4=0x44 -> cycle+1 writes r3, pendingValid=1, pendingAddress=4, mduReady=0. With WB idle at cycle+1, cycle+2 writes r4 and the block returns to IDLE.
5. STARVE_LIMIT=4, WB to r1 every cycle with MDU r4 held -> WB wins 4 cycles, then stallPipeline=1 for one cycle and r4 is written. WB r1 resumes the next cycle with no lost write.
6. Held r7=0x77, then WB r7=0x99 -> only r7=0x99 is written and pendingValid drops. Separately, assert reset while in FORCE -> no hold write and all state is zeroed.
